count_bcd_display: RTL
======================

// Module: count_bcd_display
// PURPOSE
//  Downstream consumer of the 16-bit up/down counter value.
//  Converts each accepted binary count to 5 BCD digits with a sequential
//  shift-add-3 (double-dabble) engine, one bit per cycle.
//  Drives a 5-digit, time-multiplexed, active-low 7-segment display from
//  the last completed result, with leading-zero blanking.
// PARAMETERS
//  REFRESH_CYCLES  1000  clk cycles each digit stays lit; legal range >= 2
//  BLANK_LEADING   1     1 = blank leading zero digits; 0 = show all digits
// PORTS
//  clk        in   1   system clock; all state updates on its rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  in_data    in   16  unsigned binary count, e.g. the counter's out_data
//  in_valid   in   1   in_data is offered this cycle
//  in_ready   out  1   converter idle; high means in_data is taken at the next edge
//  bcd_out    out  20  last result; {d4,d3,d2,d1,d0}, 4 bits per digit, d0 = ones
//  bcd_valid  out  1   one-cycle pulse; bcd_out was updated at the previous edge
//  seg_n      out  7   {g,f,e,d,c,b,a}, active low
//  an_n       out  5   digit enables, one-hot low; bit i drives digit di
// BEHAVIOUR
//  Reset (async, while reset_n=0):
//   - FSM=IDLE, in_ready=1, bcd_out=0, bcd_valid=0
//   - refresh counter=0, digit index=0, an_n=5'b11110, seg_n=7'b1000000 ("0")
//   - Reset during SHIFT or DONE aborts the conversion; the result is never written.
//  Converter FSM (IDLE, SHIFT, DONE):
//   - IDLE: in_ready=1. If in_valid=1 at an edge, load a 16-bit shift register
//     from in_data, clear the 20-bit BCD accumulator and bit counter, go to SHIFT.
//   - SHIFT: in_ready=0. Each cycle, add 3 to every accumulator nibble >= 5,
//     then shift {acc, shreg} left by 1. After the 16th shift, go to DONE and
//     load bcd_out from the accumulator.
//   - DONE: one cycle, bcd_valid=1, in_ready=0; then return to IDLE.
//   - Timing: accept at edge E; bcd_out updates at E+16; bcd_valid is high
//     between E+16 and E+17; the next accept is possible at E+18.
//   - in_valid while in_ready=0 is ignored; no buffering, no error flag.
//   - Result range is 0..65535; d4 is never > 6. No overflow is possible.
//  Display scanner (independent of the FSM; always reads bcd_out):
//   - Refresh counter runs 0..REFRESH_CYCLES-1 and wraps. On each wrap, the
//     digit index advances 0,1,2,3,4,0,...
//   - an_n = ~(1 << index); seg_n = decode(d[index]); both are registered,
//     so they change together on the same edge.
//   - Decode, active low, {g..a}:
//       0=1000000  1=1111001  2=0100100  3=0110000  4=0011001
//       5=0010010  6=0000010  7=1111000  8=0000000  9=0010000
//     Codes 10..15 are unreachable; drive 1111111 for them.
//   - Blanking (BLANK_LEADING=1): digit i > 0 shows 1111111 when d[i] and
//     every higher digit are 0. Digit 0 is never blanked.
//   - A bcd_out update mid-scan takes effect on the next registered segment
//     update. The scan position is not reset by the update.
// TESTING
//  1 Reset: assert reset_n=0 mid-cycle -> outputs take their reset values
//    immediately, without waiting for clk.
//  2 in_data=25, in_valid pulsed one cycle -> bcd_out=20'h00025 at E+16,
//    bcd_valid pulses once, and in_ready is high again after E+17.
//  3 in_data=65535 -> bcd_out=20'h65535; in_data=0 -> bcd_out=20'h00000;
//    in_data=10000 -> bcd_out=20'h10000.
//  4 in_valid held high with in_data changing every cycle -> only values
//    sampled in IDLE convert, one per 18 cycles; busy-cycle values are dropped.
//  5 REFRESH_CYCLES=4, bcd_out=h00025 -> an_n steps 11110,11101,11011,10111,
//    01111 every 4 cycles. seg_n is 0010010, 0100100, then 1111111 for the
//    three blanked digits.
//  6 reset_n=0 at the 8th SHIFT cycle of in_data=1234 -> bcd_out stays 0,
//    no bcd_valid; a fresh in_data=1234 then yields 20'h01234.

Source files
------------

// File: rtl/count_bcd_display.sv
`default_nettype none
// ============================================================================
// Module  : count_bcd_display
// Purpose : Takes a 16-bit unsigned count and converts it to 5 BCD digits.
//           The conversion is a sequential shift-add-3 (double-dabble) that
//           handles one bit per cycle. The last result drives a 5-digit,
//           time-multiplexed, active-low 7-segment display. Leading zero
//           digits can be blanked.
// Ports   : clk        - system clock, rising edge
//           reset_n    - asynchronous active-low reset
//           in_data    - 16-bit binary value to convert
//           in_valid   - in_data offered this cycle
//           in_ready   - converter idle; in_data is taken at the next edge
//           bcd_out    - last result {d4,d3,d2,d1,d0}, d0 = ones
//           bcd_valid  - one-cycle pulse after bcd_out was updated
//           seg_n      - segments {g,f,e,d,c,b,a}, active low
//           an_n       - digit enables, one-hot low, bit i = digit i
// Revision: 1.0 - initial release
// ============================================================================
module count_bcd_display #(
    parameter int REFRESH_CYCLES = 1000,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [19:0] bcd_out,
    output logic        bcd_valid,
    output logic [6:0]  seg_n,
    output logic [4:0]  an_n
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    localparam int c_CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_REF_MAX = c_CNT_W'(REFRESH_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [15:0] r_shreg;
    logic [19:0] r_acc;
    logic [3:0]  r_bitcnt;
    logic [19:0] w_adj;
    logic [19:0] w_shifted;

    // ------------------------------------------------------------------
    // Converter FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:  if (in_valid) w_state_next = c_S_SHIFT;
            c_S_SHIFT: if (r_bitcnt == 4'd15) w_state_next = c_S_DONE;
            c_S_DONE:  w_state_next = c_S_IDLE;
            default:   w_state_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_S_IDLE);
        bcd_valid = (r_state == c_S_DONE);
    end

    // Add 3 to every nibble >= 5 so that the following left shift carries
    // correctly into the next decimal digit.
    generate
        for (genvar i = 0; i < 5; i++) begin : g_adj
            assign w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ?
                                     r_acc[4*i +: 4] + 4'd3 : r_acc[4*i +: 4];
        end
    endgenerate

    assign w_shifted = (w_adj << 1) | {19'd0, r_shreg[15]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg  <= '0;
            r_acc    <= '0;
            r_bitcnt <= '0;
            bcd_out  <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (in_valid) begin
                        r_shreg  <= in_data;
                        r_acc    <= '0;
                        r_bitcnt <= '0;
                    end
                end
                c_S_SHIFT: begin
                    r_acc    <= w_shifted;
                    r_shreg  <= {r_shreg[14:0], 1'b0};
                    r_bitcnt <= r_bitcnt + 4'd1;
                    // Last shift: publish the finished result in the same edge.
                    if (r_bitcnt == 4'd15) begin
                        bcd_out <= w_shifted;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display scanner
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_refcnt;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_next;
    logic               w_wrap;
    logic [4:0]         w_zero;
    logic [4:0]         w_blank;
    logic [3:0]         w_digit;
    logic               w_dig_blank;
    logic [6:0]         w_seg_next;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'b1000000;
            4'd1:    f_decode = 7'b1111001;
            4'd2:    f_decode = 7'b0100100;
            4'd3:    f_decode = 7'b0110000;
            4'd4:    f_decode = 7'b0011001;
            4'd5:    f_decode = 7'b0010010;
            4'd6:    f_decode = 7'b0000010;
            4'd7:    f_decode = 7'b1111000;
            4'd8:    f_decode = 7'b0000000;
            4'd9:    f_decode = 7'b0010000;
            default: f_decode = 7'b1111111;
        endcase
    endfunction

    // A digit is blanked only when it and every higher digit are zero;
    // digit 0 always shows.
    generate
        for (genvar i = 0; i < 5; i++) begin : g_blank
            assign w_zero[i] = (bcd_out[4*i +: 4] == 4'd0);
            if (i == 0) begin : g_ones
                assign w_blank[i] = 1'b0;
            end else if (i == 4) begin : g_top
                assign w_blank[i] = BLANK_LEADING & w_zero[i];
            end else begin : g_mid
                assign w_blank[i] = w_zero[i] & w_blank[i+1];
            end
        end
    endgenerate

    assign w_wrap     = (r_refcnt == c_REF_MAX);
    assign w_idx_next = w_wrap ? ((r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1) : r_idx;

    always_comb begin
        w_digit     = bcd_out[3:0];
        w_dig_blank = w_blank[0];
        case (w_idx_next)
            3'd1: begin w_digit = bcd_out[7:4];   w_dig_blank = w_blank[1]; end
            3'd2: begin w_digit = bcd_out[11:8];  w_dig_blank = w_blank[2]; end
            3'd3: begin w_digit = bcd_out[15:12]; w_dig_blank = w_blank[3]; end
            3'd4: begin w_digit = bcd_out[19:16]; w_dig_blank = w_blank[4]; end
            default: ;
        endcase
        w_seg_next = w_dig_blank ? 7'b1111111 : f_decode(w_digit);
    end

    // an_n and seg_n are both registered from the next index, so they
    // always change on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_refcnt <= '0;
            r_idx    <= 3'd0;
            an_n     <= 5'b11110;
            seg_n    <= 7'b1000000;
        end else begin
            r_refcnt <= w_wrap ? '0 : r_refcnt + 1'b1;
            r_idx    <= w_idx_next;
            an_n     <= ~(5'b00001 << w_idx_next);
            seg_n    <= w_seg_next;
        end
    end

endmodule
`default_nettype wire
